// File: rtl/r2w1_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: requester
// indices, read-port count and round-robin pointer helpers.
package r2w1_write_arbiter_pkg;

    localparam int NUM_WB_REQ   = 3;
    localparam int NUM_RD_PORTS = 2;

    localparam int WB_REQ_ALU  = 0;
    localparam int WB_REQ_LOAD = 1;
    localparam int WB_REQ_HOST = 2;

    typedef logic [1:0] rr_ptr_t;

    // Pointer value 3 can never be produced; fold it onto 0 if it appears.
    function automatic rr_ptr_t rr_wrap(input rr_ptr_t ptr);
        return (ptr == 2'd3) ? 2'd0 : ptr;
    endfunction

    function automatic rr_ptr_t rr_inc(input rr_ptr_t ptr);
        return (ptr >= 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin pick: searches from the pointer upward
// (mod 3) and returns a one-hot grant plus the pointer that should follow it.
module rr_arbiter3
    import r2w1_write_arbiter_pkg::*;
(
    input  logic [NUM_WB_REQ-1:0] valid_i,
    input  rr_ptr_t               rr_i,
    output logic [NUM_WB_REQ-1:0] grant_o,
    output rr_ptr_t               rr_next_o
);

    rr_ptr_t idx;
    logic    found;

    always_comb begin
        grant_o   = '0;
        rr_next_o = rr_wrap(rr_i);
        idx       = rr_wrap(rr_i);
        found     = 1'b0;
        for (int k = 0; k < NUM_WB_REQ; k++) begin
            if (!found && valid_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                rr_next_o    = rr_inc(idx);
            end
            idx = rr_inc(idx);
        end
    end

endmodule

// File: rtl/r2w1_write_arbiter.sv
// Write-port owner for the 2R1W register file: round-robin writeback
// arbitration, a registered write stage, and forwarding of the last write.
module r2w1_write_arbiter
    import r2w1_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_WB_REQ-1:0] req_valid,
    output logic [NUM_WB_REQ-1:0] req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_2,
    input  logic [DATA_WIDTH-1:0] req_data_0,
    input  logic [DATA_WIDTH-1:0] req_data_1,
    input  logic [DATA_WIDTH-1:0] req_data_2,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_r_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_r_b,
    input  logic [DATA_WIDTH-1:0] ram_data_out_a,
    input  logic [DATA_WIDTH-1:0] ram_data_out_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic [15:0]           grant_count
);

    logic [ADDR_WIDTH-1:0] req_addr [NUM_WB_REQ];
    logic [DATA_WIDTH-1:0] req_data [NUM_WB_REQ];

    assign req_addr[WB_REQ_ALU]  = req_addr_0;
    assign req_addr[WB_REQ_LOAD] = req_addr_1;
    assign req_addr[WB_REQ_HOST] = req_addr_2;
    assign req_data[WB_REQ_ALU]  = req_data_0;
    assign req_data[WB_REQ_LOAD] = req_data_1;
    assign req_data[WB_REQ_HOST] = req_data_2;

    logic [NUM_WB_REQ-1:0] grant;
    rr_ptr_t               rr_q, rr_d, rr_next;

    logic                  wr_we_q, wr_we_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic [15:0]           grant_count_q, grant_count_d;

    rr_arbiter3 u_arb (
        .valid_i   (req_valid),
        .rr_i      (rr_q),
        .grant_o   (grant),
        .rr_next_o (rr_next)
    );

    assign req_ready = reset ? '0 : grant;

    always_comb begin
        wr_we_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        rr_d          = rr_q;
        grant_count_d = grant_count_q;
        for (int i = 0; i < NUM_WB_REQ; i++) begin
            if (req_ready[i]) begin
                wr_we_d   = 1'b1;
                wr_addr_d = req_addr[i];
                wr_data_d = req_data[i];
            end
        end
        if (|req_ready) begin
            rr_d          = rr_next;
            grant_count_d = grant_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_we_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            fwd_data_q    <= '0;
            rr_q          <= 2'd0;
            grant_count_q <= '0;
        end else begin
            wr_we_q       <= wr_we_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            fwd_data_q    <= wr_data_q;
            rr_q          <= rr_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign ram_we      = wr_we_q;
    assign ram_addr_w  = wr_addr_q;
    assign ram_data_in = wr_data_q;
    assign grant_count = grant_count_q;

    logic [ADDR_WIDTH-1:0] rd_addr [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0] ram_rd  [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0] rd_out  [NUM_RD_PORTS];

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign ram_rd[0]  = ram_data_out_a;
    assign ram_rd[1]  = ram_data_out_b;

    // The write committing at this edge is the one the RAM may read stale,
    // so remember whether each port's address hit it and override next cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
            logic fwd_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    fwd_q <= 1'b0;
                end else begin
                    fwd_q <= wr_we_q && (wr_addr_q == rd_addr[gi]);
                end
            end
            assign rd_out[gi] = fwd_q ? fwd_data_q : ram_rd[gi];
        end
    endgenerate

    assign ram_addr_r_a = rd_addr_a;
    assign ram_addr_r_b = rd_addr_b;
    assign rd_data_a    = rd_out[0];
    assign rd_data_b    = rd_out[1];

endmodule

// File: tb/tb_r2w1_write_arbiter.sv
// Directed bench for the write arbiter with a 2R1W RAM model that returns
// old data on read/write collision; RAM writes are checked via a scoreboard.
module tb_r2w1_write_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [3:0]  req_addr_0, req_addr_1, req_addr_2;
    logic [31:0] req_data_0, req_data_1, req_data_2;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic [3:0]  ram_addr_r_a, ram_addr_r_b;
    logic [31:0] ram_data_out_a, ram_data_out_b;
    logic [3:0]  ram_addr_w;
    logic [31:0] ram_data_in;
    logic        ram_we;
    logic [15:0] grant_count;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_cnt = 0;

    r2w1_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr_0     (req_addr_0),
        .req_addr_1     (req_addr_1),
        .req_addr_2     (req_addr_2),
        .req_data_0     (req_data_0),
        .req_data_1     (req_data_1),
        .req_data_2     (req_data_2),
        .rd_addr_a      (rd_addr_a),
        .rd_addr_b      (rd_addr_b),
        .rd_data_a      (rd_data_a),
        .rd_data_b      (rd_data_b),
        .ram_addr_r_a   (ram_addr_r_a),
        .ram_addr_r_b   (ram_addr_r_b),
        .ram_data_out_a (ram_data_out_a),
        .ram_data_out_b (ram_data_out_b),
        .ram_addr_w     (ram_addr_w),
        .ram_data_in    (ram_data_in),
        .ram_we         (ram_we),
        .grant_count    (grant_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: registered read returning pre-write contents on collision.
    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hF000_0000 | i;
    end
    always @(posedge clk) begin
        ram_data_out_a <= mem[ram_addr_r_a];
        ram_data_out_b <= mem[ram_addr_r_b];
        if (ram_we) mem[ram_addr_w] <= ram_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
        exp_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected_write observed addr=%h data=%h expected no write",
                       ram_addr_w, ram_data_in);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("sb_wr_addr", 32'(ram_addr_w), 32'(e.addr));
                chk("sb_wr_data", ram_data_in, e.data);
                $display("write addr=%h data=%h", ram_addr_w, ram_data_in);
            end
        end
    end

    initial begin
        logic [2:0] exp_g;
        reset      = 1'b1;
        req_valid  = 3'b000;
        req_addr_0 = '0; req_addr_1 = '0; req_addr_2 = '0;
        req_data_0 = '0; req_data_1 = '0; req_data_2 = '0;
        rd_addr_a  = '0; rd_addr_b  = '0;
        repeat (3) tick();

        // Reset state
        req_valid = 3'b111;
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_we", 32'(ram_we), 32'h0);
        chk("reset_cnt", 32'(grant_count), 32'h0);
        req_valid = 3'b000;
        tick();
        reset = 1'b0;

        // Single write from ALU
        req_valid = 3'b001; req_addr_0 = 4'd5; req_data_0 = 32'h1234;
        #1;
        chk("single_ready", 32'(req_ready), 32'b001);
        push_wr(4'd5, 32'h1234);
        tick();
        req_valid = 3'b000;
        #1;
        chk("single_we", 32'(ram_we), 32'h1);
        chk("single_addr", 32'(ram_addr_w), 32'h5);
        chk("single_data", ram_data_in, 32'h1234);
        chk("single_cnt", 32'(grant_count), 32'(exp_cnt));

        // Host alone from pointer 1: granted, pointer wraps back to 0
        req_valid = 3'b100; req_addr_2 = 4'd12; req_data_2 = 32'hC0DE;
        #1;
        chk("host_ready", 32'(req_ready), 32'b100);
        push_wr(4'd12, 32'hC0DE);
        tick();

        // Round robin with all three requesting continuously
        req_addr_0 = 4'd8; req_addr_1 = 4'd9; req_addr_2 = 4'd10;
        req_data_0 = 32'h0A00; req_data_1 = 32'h0B00; req_data_2 = 32'h0C00;
        req_valid  = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_g = 3'b001 << (k % 3);
            chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(exp_g));
            case (k % 3)
                0: push_wr(req_addr_0, req_data_0);
                1: push_wr(req_addr_1, req_data_1);
                default: push_wr(req_addr_2, req_data_2);
            endcase
            tick();
            chk($sformatf("rr_we_%0d", k), 32'(ram_we), 32'h1);
            case (k % 3)
                0: req_data_0 = req_data_0 + 32'h1;
                1: req_data_1 = req_data_1 + 32'h1;
                default: req_data_2 = req_data_2 + 32'h1;
            endcase
        end
        req_valid = 3'b000;
        #1;
        chk("rr_cnt", 32'(grant_count), 32'(exp_cnt));

        // Forwarding onto both ports against a stale RAM read
        req_valid = 3'b001; req_addr_0 = 4'd3; req_data_0 = 32'hAAAA;
        #1;
        chk("fwd_ready", 32'(req_ready), 32'b001);
        push_wr(4'd3, 32'hAAAA);
        tick();
        req_valid = 3'b000; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        tick();
        chk("fwd_a", rd_data_a, 32'hAAAA);
        chk("fwd_b", rd_data_b, 32'hAAAA);
        tick();
        chk("fwd_after_commit_a", rd_data_a, 32'hAAAA);

        // Pending write to r3; port a reads r4 (no forward), port b reads r3
        req_valid = 3'b010; req_addr_1 = 4'd3; req_data_1 = 32'hBBBB;
        #1;
        chk("nofwd_ready", 32'(req_ready), 32'b010);
        push_wr(4'd3, 32'hBBBB);
        tick();
        req_valid = 3'b000; rd_addr_a = 4'd4; rd_addr_b = 4'd3;
        tick();
        chk("nofwd_a", rd_data_a, 32'hF000_0004);
        chk("nofwd_b_fwd", rd_data_b, 32'hBBBB);

        // Back-to-back writes to r7 (pointer is 2 here: host first wins order)
        req_valid = 3'b101; req_addr_2 = 4'd7; req_data_2 = 32'h1;
        req_addr_0 = 4'd7; req_data_0 = 32'h2;
        #1;
        chk("b2b_ready_1", 32'(req_ready), 32'b100);
        push_wr(4'd7, 32'h1);
        tick();
        req_valid = 3'b001;
        #1;
        chk("b2b_ready_2", 32'(req_ready), 32'b001);
        push_wr(4'd7, 32'h2);
        tick();
        req_valid = 3'b000; rd_addr_a = 4'd7;
        tick();
        chk("b2b_fwd", rd_data_a, 32'h2);
        tick();
        chk("b2b_ram", rd_data_a, 32'h2);

        // Leave pointer at 2, then reset the cycle after a grant
        req_valid = 3'b010; req_addr_1 = 4'd13; req_data_1 = 32'hCCCC;
        #1;
        chk("pre_rst_ready", 32'(req_ready), 32'b010);
        push_wr(4'd13, 32'hCCCC);
        tick();
        reset = 1'b1; req_valid = 3'b110;
        #1;
        chk("rst_ready_forced", 32'(req_ready), 32'h0);
        chk("rst_pending_we", 32'(ram_we), 32'h1);
        tick();
        exp_cnt = 0;
        chk("rst_we_cleared", 32'(ram_we), 32'h0);
        chk("rst_cnt", 32'(grant_count), 32'h0);
        chk("rst_ready_hold", 32'(req_ready), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b010);
        push_wr(req_addr_1, req_data_1);
        tick();
        req_valid = 3'b000;
        #1;
        chk("post_rst_cnt", 32'(grant_count), 32'(exp_cnt));
        tick();
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
